// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared register-file definitions used by the regfile, the
//               hazard logic and the writeback queue.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // One pending writeback: destination register and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/wbq_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : wbq_fwd_match
// Description : Forwarding lookup over the occupied writeback-queue entries.
//               Returns the data of the youngest entry whose destination
//               matches the read address; register 0 never matches.
// Revision    : 1.0 - initial release
// ============================================================================
module wbq_fwd_match
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  wb_entry_t               entries [DEPTH],
    input  logic [IDX_W-1:0]        head,
    input  logic [IDX_W:0]          count,
    input  logic [REG_ADDR_W-1:0]   raddr,
    output logic                    hit,
    output logic [REG_DATA_W-1:0]   data
);

    logic [IDX_W-1:0] w_idx;

    // Walk oldest to youngest; a later match overwrites an earlier one, so
    // the entry closest to tail wins.
    always_comb begin
        hit   = 1'b0;
        data  = '0;
        w_idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = head + IDX_W'(i);
            if ((IDX_W + 1)'(i) < count
                && entries[w_idx].addr == raddr
                && raddr != ZERO_REG) begin
                hit  = 1'b1;
                data = entries[w_idx].data;
            end
        end
    end

endmodule : wbq_fwd_match
`default_nettype wire

// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_queue
// Description : Writeback queue in front of the single regfile write port.
//               Buffers late writebacks, drains them whenever the main
//               pipeline leaves the port idle, and forwards the youngest
//               pending value to both decode read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int width = REG_DATA_W,   // must equal REG_DATA_W (entry layout)
    parameter int DEPTH = 4             // power of two, >= 2
) (
    input  logic                        clk,
    input  logic                        reset,      // asynchronous, active low
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [REG_ADDR_W-1:0]       in_addr,
    input  logic [width-1:0]            in_data,
    input  logic                        port_free,
    output logic                        wr_enable,
    output logic [REG_ADDR_W-1:0]       W_addr,
    output logic [width-1:0]            W_data,
    input  logic [REG_ADDR_W-1:0]       A_addr,
    input  logic [REG_ADDR_W-1:0]       B_addr,
    output logic                        A_fwd_valid,
    output logic [width-1:0]            A_fwd_data,
    output logic                        B_fwd_valid,
    output logic [width-1:0]            B_fwd_data,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Pointers carry one wrap bit above the entry index.
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    wb_entry_t        mem_q [DEPTH];

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [IDX_W-1:0] w_head_idx;
    logic [IDX_W-1:0] w_tail_idx;

    assign w_head_idx = head_q[IDX_W-1:0];
    assign w_tail_idx = tail_q[IDX_W-1:0];

    // Occupancy flags, handshake and drain decisions from registered pointers.
    always_comb begin
        w_empty   = (head_q == tail_q);
        w_full    = (head_q[IDX_W] != tail_q[IDX_W]) && (w_head_idx == w_tail_idx);
        in_ready  = !w_full;
        // Writes to register 0 complete the handshake but are dropped here.
        w_push    = in_valid && !w_full && (in_addr != ZERO_REG);
        w_pop     = port_free && !w_empty;
        wr_enable = w_pop;
        W_addr    = w_empty ? ZERO_REG : mem_q[w_head_idx].addr;
        W_data    = w_empty ? '0 : mem_q[w_head_idx].data;
        count     = tail_q - head_q;
    end

    // Next-state pointer arithmetic; wrap falls out of the extra bit.
    always_comb begin
        head_d = head_q + PTR_W'(w_pop);
        tail_d = tail_q + PTR_W'(w_push);
    end

    // Pointer registers; reset discards every queued write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[w_tail_idx] <= '{addr: in_addr, data: in_data};
        end
    end

    wbq_fwd_match #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_fwd_a (
        .entries (mem_q),
        .head    (w_head_idx),
        .count   (count),
        .raddr   (A_addr),
        .hit     (A_fwd_valid),
        .data    (A_fwd_data)
    );

    wbq_fwd_match #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_fwd_b (
        .entries (mem_q),
        .head    (w_head_idx),
        .count   (count),
        .raddr   (B_addr),
        .hit     (B_fwd_valid),
        .data    (B_fwd_data)
    );

endmodule : regfile_wb_queue
`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_queue
// Description : Self-checking bench for regfile_wb_queue against a queue-based
//               reference model of the pending writebacks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        port_free;
    logic        wr_enable;
    logic [4:0]  W_addr;
    logic [31:0] W_data;
    logic [4:0]  A_addr;
    logic [4:0]  B_addr;
    logic        A_fwd_valid;
    logic [31:0] A_fwd_data;
    logic        B_fwd_valid;
    logic [31:0] B_fwd_data;
    logic [2:0]  count;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    regfile_wb_queue #(
        .width (32),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .port_free   (port_free),
        .wr_enable   (wr_enable),
        .W_addr      (W_addr),
        .W_data      (W_data),
        .A_addr      (A_addr),
        .B_addr      (B_addr),
        .A_fwd_valid (A_fwd_valid),
        .A_fwd_data  (A_fwd_data),
        .B_fwd_valid (B_fwd_valid),
        .B_fwd_data  (B_fwd_data),
        .count       (count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Youngest pending value for a register; register 0 is never pending.
    task automatic ref_fwd(input logic [4:0] ra, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (ra != 5'd0) begin
            foreach (q[i]) begin
                if (q[i].a == ra) begin
                    hit = 1'b1;
                    d   = q[i].d;
                end
            end
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check everything
    // before the rising edge, then advance the model across that edge.
    task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic pf, input logic [4:0] aa, input logic [4:0] ba);
        logic        e_rdy, e_we, ha, hb;
        logic [4:0]  e_wa;
        logic [31:0] e_wd, da, db;
        in_valid  = v;
        in_addr   = a;
        in_data   = d;
        port_free = pf;
        A_addr    = aa;
        B_addr    = ba;
        #1;
        e_rdy = (q.size() < DEPTH);
        e_we  = pf && (q.size() != 0);
        e_wa  = (q.size() != 0) ? q[0].a : 5'd0;
        e_wd  = (q.size() != 0) ? q[0].d : 32'd0;
        ref_fwd(aa, ha, da);
        ref_fwd(ba, hb, db);
        chk("in_ready",    64'(in_ready),    64'(e_rdy));
        chk("wr_enable",   64'(wr_enable),   64'(e_we));
        chk("W_addr",      64'(W_addr),      64'(e_wa));
        chk("W_data",      64'(W_data),      64'(e_wd));
        chk("count",       64'(count),       64'(q.size()));
        chk("A_fwd_valid", 64'(A_fwd_valid), 64'(ha));
        chk("A_fwd_data",  64'(A_fwd_data),  64'(da));
        chk("B_fwd_valid", 64'(B_fwd_valid), 64'(hb));
        chk("B_fwd_data",  64'(B_fwd_data),  64'(db));
        @(posedge clk);
        if (e_we) q.delete(0);
        if (v && e_rdy && a != 5'd0) q.push_back('{a: a, d: d});
        @(negedge clk);
    endtask

    initial begin
        // Reset asserted with a pending request and a free port.
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_addr   = 5'd5;
        in_data   = 32'h1234;
        port_free = 1'b1;
        A_addr    = 5'd5;
        B_addr    = 5'd5;
        @(posedge clk);
        @(negedge clk);
        chk("rst in_ready",    64'(in_ready),    64'd1);
        chk("rst wr_enable",   64'(wr_enable),   64'd0);
        chk("rst count",       64'(count),       64'd0);
        chk("rst W_addr",      64'(W_addr),      64'd0);
        chk("rst W_data",      64'(W_data),      64'd0);
        chk("rst A_fwd_valid", 64'(A_fwd_valid), 64'd0);
        chk("rst B_fwd_valid", 64'(B_fwd_valid), 64'd0);
        reset = 1'b1;

        // Single enqueue held back, then visible through forwarding.
        step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd0);
        step(0, 5'd0, 32'h0, 0, 5'd5, 5'd5);
        chk("single count", 64'(count), 64'd1);
        while (q.size() != 0) step(0, 5'd0, 32'h0, 1, 5'd5, 5'd0);

        // Two writes to r3: youngest forwarded, then drained in order.
        step(1, 5'd3, 32'h11, 0, 5'd3, 5'd3);
        step(1, 5'd3, 32'h22, 0, 5'd3, 5'd3);
        step(1, 5'd7, 32'h33, 0, 5'd7, 5'd3);
        step(0, 5'd0, 32'h0, 0, 5'd7, 5'd3);
        chk("B youngest r3", 64'(B_fwd_data), 64'h22);
        for (int i = 0; i < 3; i++) step(0, 5'd0, 32'h0, 1, 5'd3, 5'd7);
        chk("drained count", 64'(count), 64'd0);

        // Fill, reject while full even when a pop happens that cycle.
        for (int i = 0; i < DEPTH; i++) step(1, 5'(i + 10), 32'(i + 100), 0, 5'd10, 5'd13);
        step(1, 5'd20, 32'hBAD, 0, 5'd20, 5'd10);
        step(1, 5'd21, 32'h2121, 1, 5'd21, 5'd11);
        chk("after pop count", 64'(count), 64'd3);
        step(1, 5'd21, 32'h2121, 0, 5'd21, 5'd12);
        chk("refill count", 64'(count), 64'd4);
        while (q.size() != 0) step(0, 5'd0, 32'h0, 1, 5'd21, 5'd13);

        // Register 0 write is accepted and discarded.
        step(1, 5'd0, 32'hFFFF, 1, 5'd0, 5'd0);
        step(0, 5'd0, 32'h0, 1, 5'd0, 5'd0);

        // Asynchronous reset mid-cycle with three pending entries.
        for (int i = 0; i < 3; i++) step(1, 5'(i + 1), 32'(i + 200), 0, 5'd1, 5'd2);
        port_free = 1'b1;
        in_valid  = 1'b0;
        #1;
        chk("pre-reset wr_enable", 64'(wr_enable), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("async wr_enable", 64'(wr_enable), 64'd0);
        chk("async count",     64'(count),     64'd0);
        chk("async in_ready",  64'(in_ready),  64'd1);
        chk("async W_addr",    64'(W_addr),    64'd0);
        chk("async A_fwd",     64'(A_fwd_valid), 64'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 5'd0, 32'h0, 1, 5'd1, 5'd2);

        // Streaming enqueue + drain across several pointer wraps.
        for (int i = 0; i < 3 * DEPTH; i++)
            step(1, 5'((i % 31) + 1), 32'(i + 1000), 1, 5'((i % 31) + 1), 5'((i % 31)));
        while (q.size() != 0) step(0, 5'd0, 32'h0, 1, 5'd1, 5'd2);

        // Randomized traffic on a small register window to provoke matches.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_regfile_wb_queue
`default_nettype wire
